// File: rtl/instr_loader_pkg.sv
// Shared CPU package: loader FSM state encoding and program-length width.
package instr_loader_pkg;

    localparam int LEN_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/instr_loader_if.sv
// Control, byte-stream and instruction-memory write signals of the program loader.
interface instr_loader_if;
    import instr_loader_pkg::*;

    logic             start;
    logic [31:0]      base_addr;
    logic [LEN_W-1:0] len_words;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_ready;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wd;
    logic             cpu_hold;
    logic             busy;
    logic             done;

    modport master (
        output start, base_addr, len_words, byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wd, cpu_hold, busy, done
    );

    modport slave (
        input  start, base_addr, len_words, byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wd, cpu_hold, busy, done
    );

endinterface

// File: rtl/instr_loader.sv
// Packs a big-endian byte stream into 32-bit words written to instruction memory; mem_we lands 1 cycle after a word's 4th byte.
// byte_ready is high only while loading, so surplus source bytes stay with the source; the CPU is held until done.
module instr_loader
    import instr_loader_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    instr_loader_if.slave bus
);

    state_e           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] word_cnt_q, word_cnt_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [23:0]      asm_q, asm_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wd_q, mem_wd_d;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    addr_d     = {bus.base_addr[31:2], 2'b00};
                    len_d      = bus.len_words;
                    byte_cnt_d = 2'd0;
                    word_cnt_d = '0;
                    state_d    = (bus.len_words == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (bus.byte_valid) begin
                    // byte_cnt wraps 3 -> 0 on its own, starting the next word.
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = addr_q;
                        mem_wd_d   = {asm_q, bus.byte_data};
                        addr_d     = addr_q + 32'd4;
                        word_cnt_d = word_cnt_q + LEN_W'(1);
                        if (word_cnt_q == len_q - LEN_W'(1)) begin
                            state_d = ST_FLUSH;
                        end
                    end else begin
                        asm_d = {asm_q[15:0], bus.byte_data};
                    end
                end
            end
            ST_FLUSH: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
        end
    end

    assign bus.byte_ready = (state_q == ST_LOAD);
    assign bus.busy       = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.cpu_hold   = (state_q != ST_DONE);
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wd     = mem_wd_q;

endmodule
